// File: rtl/fixed_acc_pkg.sv
// rtl/fixed_acc_pkg.sv - op encodings, FSM state type and channel-index width helper
package fixed_acc_pkg;

   localparam logic [1:0] OP_ACCUM     = 2'd0;
   localparam logic [1:0] OP_READ      = 2'd1;
   localparam logic [1:0] OP_CLEAR     = 2'd2;
   localparam logic [1:0] OP_CLEAR_ALL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CLR  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   function automatic int ch_bits(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/fixed_acc_mc_if.sv
// rtl/fixed_acc_mc_if.sv - custom-instruction request/response bundle
interface fixed_acc_mc_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       n;
   logic [WIDTH-1:0] dataa;
   logic [WIDTH-1:0] datab;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             xo;
   logic             xu;
   logic             ao;

   modport master (output start, n, dataa, datab, input result, done, xo, xu, ao);
   modport slave  (input start, n, dataa, datab, output result, done, xo, xu, ao);
endinterface

// File: rtl/fixed_acc_core.sv
// rtl/fixed_acc_core.sv - add/overflow/clamp datapath shared by ACCUM and READ
// FIXED_ACC_SAT_EN: saturate the stored accumulator on overflow instead of wrapping.
module fixed_acc_core #(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]     addend,
   output logic [ACC_WIDTH-1:0] acc_next,
   output logic                 ovf,
   output logic [WIDTH-1:0]     clamped,
   output logic                 xo,
   output logic                 xu
);
   localparam int GUARD = ACC_WIDTH - WIDTH;

   logic [ACC_WIDTH-1:0] ext;
   logic [ACC_WIDTH-1:0] sum;
   logic                 fits;

   always_comb begin
      ext = {{GUARD{addend[WIDTH-1]}}, addend};
      sum = acc + ext;
      ovf = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
`ifdef FIXED_ACC_SAT_EN
      if (ovf) begin
         acc_next = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         acc_next = sum;
      end
`else
      acc_next = sum;
`endif
      // The value fits in WIDTH when all guard bits replicate the WIDTH sign bit.
      fits    = (acc_next[ACC_WIDTH-1:WIDTH-1] == {(GUARD+1){acc_next[ACC_WIDTH-1]}});
      xo      = !fits && !acc_next[ACC_WIDTH-1];
      xu      = !fits && acc_next[ACC_WIDTH-1];
      if (fits) begin
         clamped = acc_next[WIDTH-1:0];
      end else if (acc_next[ACC_WIDTH-1]) begin
         clamped = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         clamped = {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
endmodule

// File: rtl/fixed_acc_mc.sv
// rtl/fixed_acc_mc.sv - multi-channel signed fixed-point accumulator, multicycle custom instruction
// FIXED_ACC_SAT_EN selects saturating (defined) or wrapping (undefined) accumulator storage.
module fixed_acc_mc
   import fixed_acc_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ACC_WIDTH = 40,
   parameter int CHANNELS  = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clk_en,
   fixed_acc_mc_if.slave bus
);
   localparam int CB = ch_bits(CHANNELS);

   state_t state, state_nx;

   logic [1:0]           op_q;
   logic [WIDTH-1:0]     addend_q;
   logic [CB-1:0]        ch_q;
   logic [CB-1:0]        cnt;
   logic [ACC_WIDTH-1:0] acc_mem [CHANNELS];
   logic [CHANNELS-1:0]  ao_mem;

   logic [WIDTH-1:0]     res_p;
   logic                 xo_p, xu_p, ao_p;
   logic [WIDTH-1:0]     result_q;
   logic                 done_q, xo_q, xu_q, ao_q;

   logic [ACC_WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0]     core_res;
   logic                 core_ovf, core_xo, core_xu;
   logic [WIDTH-1:0]     core_addend;
   logic                 unused_datab;

   assign unused_datab = ^bus.datab[WIDTH-1:CB];

   // READ reuses the adder with a zero addend so clamping logic exists once.
   assign core_addend = (op_q == OP_ACCUM) ? addend_q : '0;

   fixed_acc_core #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_core (
      .acc      (acc_mem[ch_q]),
      .addend   (core_addend),
      .acc_next (acc_nx),
      .ovf      (core_ovf),
      .clamped  (core_res),
      .xo       (core_xo),
      .xu       (core_xu)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else if (clk_en) begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (bus.start) state_nx = (bus.n == OP_CLEAR_ALL) ? ST_CLR : ST_EXEC;
         ST_EXEC: state_nx = ST_RESP;
         ST_CLR:  if (cnt == CB'(CHANNELS-1)) state_nx = ST_RESP;
         ST_RESP: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) acc_mem[i] <= '0;
         ao_mem   <= '0;
         op_q     <= OP_ACCUM;
         addend_q <= '0;
         ch_q     <= '0;
         cnt      <= '0;
         res_p    <= '0;
         xo_p     <= 1'b0;
         xu_p     <= 1'b0;
         ao_p     <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         xo_q     <= 1'b0;
         xu_q     <= 1'b0;
         ao_q     <= 1'b0;
      end else if (clk_en) begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  op_q     <= bus.n;
                  addend_q <= bus.dataa;
                  ch_q     <= bus.datab[CB-1:0];
                  cnt      <= '0;
               end
            end
            ST_EXEC: begin
               if (op_q == OP_ACCUM) begin
                  acc_mem[ch_q] <= acc_nx;
                  if (core_ovf) ao_mem[ch_q] <= 1'b1;
                  res_p <= core_res;
                  xo_p  <= core_xo;
                  xu_p  <= core_xu;
                  ao_p  <= ao_mem[ch_q] | core_ovf;
               end else if (op_q == OP_READ) begin
                  res_p <= core_res;
                  xo_p  <= core_xo;
                  xu_p  <= core_xu;
                  ao_p  <= ao_mem[ch_q];
               end else begin
                  acc_mem[ch_q] <= '0;
                  ao_mem[ch_q]  <= 1'b0;
                  res_p <= '0;
                  xo_p  <= 1'b0;
                  xu_p  <= 1'b0;
                  ao_p  <= 1'b0;
               end
            end
            ST_CLR: begin
               acc_mem[cnt] <= '0;
               ao_mem[cnt]  <= 1'b0;
               cnt   <= cnt + 1'b1;
               res_p <= '0;
               xo_p  <= 1'b0;
               xu_p  <= 1'b0;
               ao_p  <= 1'b0;
            end
            ST_RESP: begin
               result_q <= res_p;
               xo_q     <= xo_p;
               xu_q     <= xu_p;
               ao_q     <= ao_p;
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.result = result_q;
   assign bus.done   = done_q;
   assign bus.xo     = xo_q;
   assign bus.xu     = xu_q;
   assign bus.ao     = ao_q;
endmodule
